// File: rtl/opb_register_ppc2simulink_sc.sv
// OPB slave with one 32-bit control register that the PPC writes and reads back.
// The register contents drive fabric logic; every effective write raises a one-cycle update pulse.
module opb_register_ppc2simulink_sc #(
   parameter logic [31:0] C_BASEADDR    = 32'h0000_0000,
   parameter logic [31:0] C_HIGHADDR    = 32'h0000_00FF,
   parameter int          C_OPB_AWIDTH  = 32,
   parameter int          C_OPB_DWIDTH  = 32,
   parameter              C_FAMILY      = "virtex5",
   parameter logic [31:0] C_RESET_VALUE = 32'h0000_0000
) (
   input  logic        OPB_Clk,
   input  logic        OPB_Rst_n,
   output logic [0:31] Sl_DBus,
   output logic        Sl_errAck,
   output logic        Sl_retry,
   output logic        Sl_toutSup,
   output logic        Sl_xferAck,
   input  logic [0:31] OPB_ABus,
   input  logic [0:3]  OPB_BE,
   input  logic [0:31] OPB_DBus,
   input  logic        OPB_RNW,
   input  logic        OPB_select,
   input  logic        OPB_seqAddr,
   output logic [31:0] user_data_out,
   output logic        user_update
);

   typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_take;
   logic [31:0] w_addr;
   logic [31:0] w_offset;
   logic        w_hit;
   logic        w_off0;
   logic [31:0] w_wdata;
   logic [3:0]  w_be;
   logic [31:0] w_mask;
   logic        w_wr_en;
   logic        w_rd_en;
   logic [31:0] r_user;
   logic [31:0] r_dbus;
   logic        r_update;
   logic        w_unused;

   if (C_OPB_AWIDTH != 32 || C_OPB_DWIDTH != 32) begin : g_bad_width
      $error("opb_register_ppc2simulink_sc supports only 32-bit OPB address and data");
   end

   // OPB numbers bit 0 as the MSB, so a straight vector copy already realises bit i <-> bit 31-i.
   assign w_addr   = OPB_ABus;
   assign w_wdata  = OPB_DBus;
   assign w_be     = OPB_BE;
   assign w_offset = w_addr - C_BASEADDR;
   assign w_hit    = OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);
   assign w_off0   = (w_offset[31:2] == 30'd0);
   assign w_mask   = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};

   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_hit) begin
               w_state_nxt = S_ACK;
               w_take      = 1'b1;
            end
         end
         S_ACK: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_wr_en = w_take && !OPB_RNW && w_off0 && (w_be != 4'b0000);
   assign w_rd_en = w_take && OPB_RNW && w_off0;

   always_ff @(posedge OPB_Clk) begin
      if (!OPB_Rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Read data is only non-zero in the ack cycle, so the bus can be wire-ORed with other slaves.
   always_ff @(posedge OPB_Clk) begin
      if (!OPB_Rst_n) begin
         r_user   <= C_RESET_VALUE;
         r_dbus   <= 32'd0;
         r_update <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_user <= (r_user & ~w_mask) | (w_wdata & w_mask);
         end
         r_dbus   <= w_rd_en ? r_user : 32'd0;
         r_update <= w_wr_en;
      end
   end

   assign Sl_DBus       = r_dbus;
   assign Sl_xferAck    = (r_state == S_ACK);
   assign Sl_errAck     = 1'b0;
   assign Sl_retry      = 1'b0;
   assign Sl_toutSup    = 1'b0;
   assign user_data_out = r_user;
   assign user_update   = r_update;

   assign w_unused = ^{OPB_seqAddr, w_offset[1:0], C_FAMILY};

endmodule

// File: tb/tb_opb_register_ppc2simulink_sc.sv
// Randomised bench for opb_register_ppc2simulink_sc against a transaction-level model,
// plus directed scenarios with literal expectations.
module tb_opb_register_ppc2simulink_sc;

   localparam logic [31:0] BASE = 32'h0109_4B00;
   localparam logic [31:0] HIGH = 32'h0109_4BFF;
   localparam logic [31:0] RSTV = 32'hA5A5_0001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [0:31] sl_dbus;
   logic        sl_errack, sl_retry, sl_toutsup, sl_xferack;
   logic [0:31] abus = '0;
   logic [0:3]  be = '0;
   logic [0:31] dbus = '0;
   logic        rnw = 1'b0;
   logic        sel = 1'b0;
   logic        seqaddr = 1'b0;
   logic [31:0] user_data;
   logic        user_upd;

   int n_vec = 0;
   int n_err = 0;
   int ack_cnt = 0;
   int upd_cnt = 0;
   bit chk_en = 1'b0;

   // model state: what the outputs must be in the current cycle
   logic        m_ack = 1'b0;
   logic [31:0] m_dbus = '0;
   logic        m_upd = 1'b0;
   logic [31:0] m_reg = RSTV;

   opb_register_ppc2simulink_sc #(
      .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
      .C_FAMILY("virtex5"), .C_RESET_VALUE(RSTV)
   ) dut (
      .OPB_Clk(clk), .OPB_Rst_n(rst_n), .Sl_DBus(sl_dbus), .Sl_errAck(sl_errack),
      .Sl_retry(sl_retry), .Sl_toutSup(sl_toutsup), .Sl_xferAck(sl_xferack),
      .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus), .OPB_RNW(rnw),
      .OPB_select(sel), .OPB_seqAddr(seqaddr), .user_data_out(user_data),
      .user_update(user_upd)
   );

   always #5 clk = ~clk;

   // Transaction-level model: a transfer is accepted only when no ack is in flight.
   always @(posedge clk) begin
      logic [31:0] a, nv, d;
      logic        hit, word0;
      a     = abus;
      d     = dbus;
      hit   = sel && (a >= BASE) && (a <= HIGH);
      word0 = ((a - BASE) / 4) == 0;
      nv    = m_reg;
      if (!rst_n) begin
         m_ack  <= 1'b0;
         m_dbus <= '0;
         m_upd  <= 1'b0;
         m_reg  <= RSTV;
      end else if (!m_ack && hit) begin
         m_ack <= 1'b1;
         if (rnw) begin
            m_dbus <= word0 ? m_reg : 32'd0;
            m_upd  <= 1'b0;
         end else begin
            for (int i = 0; i < 4; i++)
               if (be[i] && word0) nv[31-8*i -: 8] = d[31-8*i -: 8];
            m_reg  <= nv;
            m_dbus <= '0;
            m_upd  <= word0 && (be != 4'b0000);
         end
      end else begin
         m_ack  <= 1'b0;
         m_dbus <= '0;
         m_upd  <= 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("xferAck", {31'd0, sl_xferack}, {31'd0, m_ack});
         check("Sl_DBus", sl_dbus, m_dbus);
         check("user_update", {31'd0, user_upd}, {31'd0, m_upd});
         check("user_data_out", user_data, m_reg);
         check("tied_outputs", {29'd0, sl_errack, sl_retry, sl_toutsup}, 32'd0);
         if (sl_xferack) ack_cnt++;
         if (user_upd) upd_cnt++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic r, input logic [3:0] b,
                        input logic [31:0] d);
      abus = a; rnw = r; be = b; dbus = d; sel = 1'b1;
   endtask

   // One select cycle, then select dropped; returns at the start of the ack cycle.
   task automatic xfer(input logic [31:0] a, input logic r, input logic [3:0] b,
                       input logic [31:0] d);
      drive(a, r, b, d);
      step();
      sel = 1'b0;
      abus = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      step();
      chk_en = 1'b1;
      step();
      rst_n = 1'b1;
      step();
      // 1: reset state
      check("reset_value", user_data, 32'hA5A5_0001);
      check("reset_ack", {31'd0, sl_xferack}, 32'd0);
      check("reset_dbus", sl_dbus, 32'd0);

      // 2: full write then readback
      ack_cnt = 0; upd_cnt = 0;
      xfer(BASE, 1'b0, 4'b1111, 32'hDEADBEEF);
      check("wr_ack", {31'd0, sl_xferack}, 32'd1);
      check("wr_value", user_data, 32'hDEADBEEF);
      check("wr_pulse", {31'd0, user_upd}, 32'd1);
      step();
      check("wr_ack_gone", {31'd0, sl_xferack}, 32'd0);
      xfer(BASE, 1'b1, 4'b1111, 32'h0);
      check("rd_dbus", sl_dbus, 32'hDEADBEEF);
      step();
      check("rd_dbus_after", sl_dbus, 32'd0);
      check("one_update", upd_cnt, 1);

      // 3: byte lanes
      xfer(BASE, 1'b0, 4'b0101, 32'h11223344);
      check("be0101_value", user_data, 32'hDE22BE44);
      check("be0101_pulse", {31'd0, user_upd}, 32'd1);
      step();
      xfer(BASE, 1'b0, 4'b0000, 32'hFFFFFFFF);
      check("be0000_ack", {31'd0, sl_xferack}, 32'd1);
      check("be0000_value", user_data, 32'hDE22BE44);
      check("be0000_nopulse", {31'd0, user_upd}, 32'd0);
      step();

      // 4: window edges
      xfer(BASE + 32'h10, 1'b0, 4'b1111, 32'h12345678);
      check("off10_wr_value", user_data, 32'hDE22BE44);
      step();
      xfer(BASE + 32'h10, 1'b1, 4'b1111, 32'h0);
      check("off10_rd_ack", {31'd0, sl_xferack}, 32'd1);
      check("off10_rd_dbus", sl_dbus, 32'd0);
      step();
      xfer(HIGH, 1'b1, 4'b1111, 32'h0);
      check("high_ack", {31'd0, sl_xferack}, 32'd1);
      step();
      xfer(HIGH + 32'd1, 1'b1, 4'b1111, 32'h0);
      check("high_plus1_noack", {31'd0, sl_xferack}, 32'd0);
      step();
      xfer(BASE - 32'd4, 1'b1, 4'b1111, 32'h0);
      check("base_minus4_noack", {31'd0, sl_xferack}, 32'd0);
      check("base_minus4_dbus", sl_dbus, 32'd0);
      step();

      // 5: select held for 6 cycles
      step();
      ack_cnt = 0; upd_cnt = 0;
      drive(BASE, 1'b0, 4'b1111, 32'hCAFEF00D);
      repeat (6) step();
      sel = 1'b0;
      step(); step();
      check("held_acks", ack_cnt, 3);
      check("held_updates", upd_cnt, 3);

      // 6: reset in the cycle of a write hit
      drive(BASE, 1'b0, 4'b1111, 32'h0BADF00D);
      rst_n = 1'b0;
      step();
      sel = 1'b0;
      rst_n = 1'b1;
      check("rst_hit_noack", {31'd0, sl_xferack}, 32'd0);
      check("rst_hit_nopulse", {31'd0, user_upd}, 32'd0);
      check("rst_hit_value", user_data, 32'hA5A5_0001);
      step();

      // random traffic
      for (int n = 0; n < 600; n++) begin
         logic [31:0] a;
         case ($urandom_range(0, 6))
            0, 1: a = BASE;
            2: a = BASE + 32'h10;
            3: a = HIGH;
            4: a = HIGH + 32'd1;
            5: a = BASE - 32'd4;
            default: a = $urandom;
         endcase
         abus = a;
         rnw = $urandom_range(0, 1);
         be = $urandom_range(0, 15);
         dbus = $urandom;
         sel = ($urandom_range(0, 3) != 0);
         seqaddr = $urandom_range(0, 1);
         rst_n = ($urandom_range(0, 49) != 0);
         step();
      end
      sel = 1'b0;
      rst_n = 1'b1;
      step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/opb_register_ppc2simulink_sc.md
Name: opb_register_ppc2simulink_sc

Overview:
- OPB slave holding one 32-bit control register. The PPC writes it and reads it back, and its value drives fabric logic as `user_data_out`.
- Complement of the simulink2ppc status registers, e.g. a PPS-count readout. This block carries data PPC→fabric, not fabric→PPC.
- Single clock domain: fabric logic runs on OPB_Clk, so there is no CDC stage.
- Byte-lane writes are supported, and a one-cycle `user_update` strobe flags every effective write.

Parameters:
- C_BASEADDR, 32'h00000000, first byte address of the slave window.
- C_HIGHADDR, 32'h000000FF, last byte address of the slave window (inclusive).
- C_OPB_AWIDTH, 32, OPB address width; only 32 is supported.
- C_OPB_DWIDTH, 32, OPB data width; only 32 is supported.
- C_FAMILY, "virtex5", target family; informational only.
- C_RESET_VALUE, 32'h00000000, value loaded into the register at reset.

Ports:
- OPB_Clk  in  1  sole clock, rising edge.
- OPB_Rst_n  in  1  synchronous, active-low reset.
- Sl_DBus  out  [0:31]  read data; 0 whenever Sl_xferAck=0.
- Sl_errAck  out  1  tied 0.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- Sl_xferAck  out  1  transfer acknowledge.
- OPB_ABus  in  [0:31]  address.
- OPB_BE  in  [0:3]  byte enables; BE[0] selects DBus[0:7].
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1=read, 0=write.
- OPB_select  in  1  transfer valid.
- OPB_seqAddr  in  1  ignored.
- user_data_out  out  [31:0]  register contents, driven to fabric.
- user_update  out  1  one-cycle pulse after an effective write.

Behaviour:

Decoding and bit mapping:
- Hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR, compared unsigned.
- Offset: OPB_ABus - C_BASEADDR, bits [1:0] ignored.
- Word offset 0 is the register. All other words in the window read 0 and ignore writes, but are still acknowledged.
- Bit mapping: OPB bit i ↔ user bit 31-i. BE[0]→[31:24], BE[1]→[23:16], BE[2]→[15:8], BE[3]→[7:0].

FSM states: IDLE, ACK.
- IDLE, hit → ACK. On that edge:
  - Write at offset 0: each byte with BE=1 is loaded from OPB_DBus; bytes with BE=0 are unchanged.
  - Read: the readback word is captured into the Sl_DBus register.
- IDLE, no hit → IDLE. Outputs stay at 0.
- ACK → IDLE unconditionally.
  - Sl_xferAck=1 for exactly this one cycle.
  - On a read, Sl_DBus holds the captured value this cycle; otherwise Sl_DBus=0.
  - The mandatory IDLE cycle guarantees one ack per transfer, even if the master holds OPB_select high.

Latency:
- Select/hit in cycle N → Sl_xferAck in cycle N+1.
- After a write, the new user_data_out is visible from cycle N+1, coincident with Sl_xferAck.
- Throughput is at most one transfer per 2 cycles.

user_update:
- Registered; pulses high in cycle N+1 only for a write at offset 0 with BE≠0000.
- No pulse for reads, BE=0000, or non-zero offsets.

Reset:
- While OPB_Rst_n=0 at a rising edge, the next cycle has: state=IDLE, user_data_out=C_RESET_VALUE, Sl_DBus=0, Sl_xferAck=0, user_update=0.
- Reset asserted while in ACK: the next cycle has no ack and no pulse.
- A write latched in the same cycle as a reset edge is discarded; reset wins.

Other boundary conditions:
- OPB_select dropped during ACK: the ack still completes, since it was already committed.
- An address exactly equal to C_HIGHADDR is a hit; C_HIGHADDR+1 is not.
- Register updates occur only in the IDLE→ACK transition; simultaneous read and write cannot occur.

Test Plan:
1. Reset with C_RESET_VALUE=32'hA5A5_0001, then release → user_data_out=A5A50001; Sl_xferAck, Sl_DBus, user_update all 0.
2. Write 32'hDEADBEEF, BE=1111, at C_BASEADDR=32'h01094B00 → xferAck one cycle later; user_data_out=DEADBEEF in the same cycle; user_update pulses once. Then read → Sl_DBus=DEADBEEF during ack only, 0 otherwise.
3. Starting from DEADBEEF, write 32'h11223344 with BE=0101 → user_data_out=DE22BE44 with one update pulse. Then write with BE=0000 → acked, value unchanged, no pulse.
4. Accesses at base+0x10 (read returns 0, write ignored, both acked, no pulse), at C_HIGHADDR (acked), and at C_HIGHADDR+1 and at base-4 (no ack, Sl_DBus=0).
5. Hold OPB_select high with the same write for 6 cycles → exactly 3 single-cycle acks, alternating with IDLE cycles; 3 update pulses.
6. Assert OPB_Rst_n=0 in the cycle of a write hit → no ack and no pulse next cycle; user_data_out=C_RESET_VALUE.
